// File: rtl/iobus_pkg.sv
// Shared types and MMIO address map for the OTTER IOBUS initiator.
// Holds the command record that the queue stores and the engine's state encoding.
package iobus_pkg;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } iobus_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [31:0] SWITCHES_AD = 32'h11000000;
    localparam logic [31:0] LEDS_AD     = 32'h11080000;
    localparam logic [31:0] SSEG_AD     = 32'h110C0000;

endpackage

// File: rtl/iobus_cmd_fifo.sv
// Synchronous command queue for the IOBUS initiator.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
import iobus_pkg::*;

module cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  iobus_cmd_t wdata,
    input  logic       pop,
    output iobus_cmd_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    iobus_cmd_t  mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only read once the pointers say they are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/iobus_initiator.sv
// Bus-master engine that replays queued commands onto the OTTER IOBUS.
// One command is in flight at a time; reads return through a valid/ready response port.
import iobus_pkg::*;

module iobus_initiator #(
    parameter int FIFO_DEPTH = 4,
    parameter int READ_WAIT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] iobus_addr,
    output logic [31:0] iobus_out,
    output logic        iobus_wr,
    input  logic [31:0] iobus_in,
    output logic        busy
);

    localparam logic [3:0] WAIT_LOAD = 4'(READ_WAIT);

    state_t     state;
    state_t     state_next;
    iobus_cmd_t head;
    iobus_cmd_t push_cmd;
    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       capture;
    logic       load_cnt;
    logic       cur_wr;
    logic [3:0] wait_cnt;

    assign push_cmd  = '{wr: cmd_wr, addr: cmd_addr, data: cmd_data};
    assign cmd_ready = rst_n && !full;
    assign push      = cmd_valid && cmd_ready;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        load_cnt   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_wr) begin
                    state_next = IDLE;
                end else if (WAIT_LOAD == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    load_cnt   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd1) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Bus registers hold the last command until the next pop, so the address stays put through WAIT and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_wr     <= 1'b0;
            iobus_addr <= '0;
            iobus_out  <= '0;
            wait_cnt   <= '0;
            rsp_data   <= '0;
        end else begin
            if (pop) begin
                cur_wr     <= head.wr;
                iobus_addr <= head.addr;
                iobus_out  <= head.data;
            end
            if (load_cnt)          wait_cnt <= WAIT_LOAD;
            else if (state == WAIT) wait_cnt <= wait_cnt - 4'd1;
            if (capture) rsp_data <= iobus_in;
        end
    end

    assign iobus_wr  = (state == ISSUE) && cur_wr;
    assign rsp_valid = (state == RESP);
    assign busy      = !empty || (state != IDLE);

endmodule

// File: tb/tb_iobus_initiator.sv
// Self-checking bench for iobus_initiator with FIFO_DEPTH = 4 and READ_WAIT = 2.
// A monitor logs accepted commands and observed bus events; a scoreboard pairs them in order.
import iobus_pkg::*;

module tb_iobus_initiator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] iobus_in;
    logic        busy;

    iobus_initiator #(
        .FIFO_DEPTH (4),
        .READ_WAIT  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .iobus_addr (iobus_addr),
        .iobus_out  (iobus_out),
        .iobus_wr   (iobus_wr),
        .iobus_in   (iobus_in),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bus_model(input logic [31:0] a);
        return (a == SWITCHES_AD) ? 32'h0000BEEF : (a ^ 32'h5A5A5A5A);
    endfunction

    always_comb iobus_in = bus_model(iobus_addr);

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_data;
    } vec_t;

    ev_t acc_q[$];
    ev_t obs_q[$];
    int  tests = 0;
    int  fails = 0;
    int  exp_i = 0;
    int  obs_i = 0;

    // Handshakes are stable between the falling edge and the next rising edge that acts on them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) acc_q.push_back('{cmd_wr, cmd_addr, cmd_data});
            if (iobus_wr)               obs_q.push_back('{1'b1, iobus_addr, iobus_out});
            if (rsp_valid && rsp_ready) obs_q.push_back('{1'b0, iobus_addr, rsp_data});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = v;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_data  = d;
    endtask

    task automatic checkScoreboard(input string tag);
        while (exp_i < acc_q.size()) begin
            ev_t e;
            ev_t o;
            e = acc_q[exp_i];
            if (!e.wr) e.data = bus_model(e.addr);
            if (obs_i >= obs_q.size()) begin
                tests++;
                fails++;
                $display("[TB] FAIL %s missing: got %0d events, expected %0d more", tag, 0, acc_q.size() - exp_i);
                exp_i = acc_q.size();
                break;
            end
            o = obs_q[obs_i];
            checkOutput({tag, " kind"}, {31'd0, o.wr}, {31'd0, e.wr});
            checkOutput({tag, " addr"}, o.addr, e.addr);
            checkOutput({tag, " data"}, o.data, e.data);
            exp_i++;
            obs_i++;
        end
        checkOutput({tag, " event count"}, obs_q.size(), obs_i);
    endtask

    task automatic drain(input string tag);
        applyStimulus(0, 0, '0, '0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && busy; i++) step();
        checkOutput({tag, " drain busy"}, {31'd0, busy}, 32'd0);
        checkScoreboard(tag);
    endtask

    task automatic doWriteCheck(input string tag);
        applyStimulus(1, 1, LEDS_AD, 32'h0000A5A5);
        checkOutput({tag, " ready k"}, {31'd0, cmd_ready}, 32'd1);
        step();
        applyStimulus(0, 0, '0, '0);
        checkOutput({tag, " wr k+1"}, {31'd0, iobus_wr}, 32'd0);
        checkOutput({tag, " busy k+1"}, {31'd0, busy}, 32'd1);
        step();
        checkOutput({tag, " wr k+2"}, {31'd0, iobus_wr}, 32'd1);
        checkOutput({tag, " addr k+2"}, iobus_addr, LEDS_AD);
        checkOutput({tag, " out k+2"}, iobus_out, 32'h0000A5A5);
        step();
        checkOutput({tag, " wr k+3"}, {31'd0, iobus_wr}, 32'd0);
        checkOutput({tag, " busy k+3"}, {31'd0, busy}, 32'd0);
        step();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, LEDS_AD,      32'h0000A5A5, 32'h0000A5A5};
        vecs[1] = '{1'b1, SSEG_AD,      32'h00001234, 32'h00001234};
        vecs[2] = '{1'b0, SWITCHES_AD,  32'hDEADDEAD, 32'h0000BEEF};
        vecs[3] = '{1'b0, LEDS_AD,      32'h00000000, 32'h4B525A5A};
        vecs[4] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{1'b0, SSEG_AD,      32'h00000000, 32'h4B565A5A};

        // Reset held for three cycles.
        repeat (3) step();
        checkOutput("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset rsp_data", rsp_data, 32'd0);
        checkOutput("reset iobus_addr", iobus_addr, 32'd0);
        checkOutput("reset iobus_out", iobus_out, 32'd0);
        checkOutput("reset iobus_wr", {31'd0, iobus_wr}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("release cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("release busy", {31'd0, busy}, 32'd0);
        step();

        doWriteCheck("single write");

        // Table of single commands issued from idle, reads held in RESP for a while.
        foreach (vecs[n]) begin
            rsp_ready = 1'b0;
            applyStimulus(1, vecs[n].wr, vecs[n].addr, vecs[n].data);
            step();
            applyStimulus(0, 0, '0, '0);
            if (vecs[n].wr) begin
                step();
                checkOutput($sformatf("vec%0d wr", n), {31'd0, iobus_wr}, 32'd1);
                checkOutput($sformatf("vec%0d addr", n), iobus_addr, vecs[n].addr);
                checkOutput($sformatf("vec%0d out", n), iobus_out, vecs[n].exp_data);
                step();
                checkOutput($sformatf("vec%0d wr after", n), {31'd0, iobus_wr}, 32'd0);
            end else begin
                for (int j = 1; j <= 4; j++) begin
                    checkOutput($sformatf("vec%0d rsp_valid k+%0d", n, j), {31'd0, rsp_valid}, 32'd0);
                    checkOutput($sformatf("vec%0d read wr k+%0d", n, j), {31'd0, iobus_wr}, 32'd0);
                    step();
                end
                checkOutput($sformatf("vec%0d rsp_valid k+5", n), {31'd0, rsp_valid}, 32'd1);
                checkOutput($sformatf("vec%0d rsp_data", n), rsp_data, vecs[n].exp_data);
                step();
                step();
                checkOutput($sformatf("vec%0d rsp held", n), {31'd0, rsp_valid}, 32'd1);
                checkOutput($sformatf("vec%0d data held", n), rsp_data, vecs[n].exp_data);
                checkOutput($sformatf("vec%0d addr held", n), iobus_addr, vecs[n].addr);
                rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
                checkOutput($sformatf("vec%0d rsp done", n), {31'd0, rsp_valid}, 32'd0);
            end
            step();
        end
        checkScoreboard("table");

        // Stalled read fills the queue; writes then drain two cycles apart.
        applyStimulus(1, 0, SWITCHES_AD, '0);
        step();
        applyStimulus(0, 0, '0, '0);
        repeat (4) step();
        checkOutput("stall rsp_valid", {31'd0, rsp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, LEDS_AD + i, 32'hC0DE0000 + i);
            checkOutput($sformatf("fill ready %0d", i), {31'd0, cmd_ready}, (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        applyStimulus(0, 0, '0, '0);
        checkOutput("full ready", {31'd0, cmd_ready}, 32'd0);
        checkOutput("full iobus_wr", {31'd0, iobus_wr}, 32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        checkOutput("unstall rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("unstall ready", {31'd0, cmd_ready}, 32'd0);
        step();
        checkOutput("after pop ready", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("burst wr %0d", i), {31'd0, iobus_wr}, 32'd1);
            checkOutput($sformatf("burst addr %0d", i), iobus_addr, LEDS_AD + i);
            checkOutput($sformatf("burst out %0d", i), iobus_out, 32'hC0DE0000 + i);
            step();
            checkOutput($sformatf("burst gap %0d", i), {31'd0, iobus_wr}, 32'd0);
            step();
        end
        checkOutput("burst busy", {31'd0, busy}, 32'd0);
        checkScoreboard("burst");

        // Back-to-back write stream with push and pop overlapping.
        rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1, 1, SSEG_AD, $urandom);
            step();
        end
        drain("stream");

        // Random mixed traffic with random response back-pressure.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = SWITCHES_AD;
                1:       a = LEDS_AD;
                2:       a = SSEG_AD;
                default: a = $urandom;
            endcase
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("random");

        // Reset during WAIT discards the read in flight.
        rsp_ready = 1'b1;
        applyStimulus(1, 0, SWITCHES_AD, '0);
        step();
        applyStimulus(0, 0, '0, '0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("midreset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midreset busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset iobus_wr", {31'd0, iobus_wr}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("post reset rsp_valid %0d", i), {31'd0, rsp_valid}, 32'd0);
            step();
        end
        exp_i = acc_q.size();
        checkScoreboard("post reset");
        doWriteCheck("write after reset");
        checkScoreboard("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iobus_initiator.md
# iobus_initiator

Bus-master engine for the OTTER memory-mapped IOBUS. It drives the initiator side of the bus, the same side the MCU occupies, so MMIO peripherals (LEDS, SSEG, SWITCHES) can be exercised by a command stream without the CPU. Commands enter through a valid/ready port and queue in a small FIFO. They are issued to the bus one at a time, and read data comes back through a valid/ready response port.

## Interface
- FIFO_DEPTH, 4: command queue entries; power of two, ≥2.
- READ_WAIT, 1: extra cycles the read address is held before IOBUS_IN is sampled; range 0–15.

- CLK  in  1  sole clock; all state changes on its rising edge.
- RST_N  in  1  reset, asynchronous and active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  queue can accept a command.
- CMD_WR  in  1  1 = write, 0 = read.
- CMD_ADDR  in  32  target IOBUS address.
- CMD_DATA  in  32  write data; ignored for reads.
- RSP_VALID  out  1  read data available.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DATA  out  32  captured IOBUS_IN.
- IOBUS_ADDR  out  32  bus address.
- IOBUS_OUT  out  32  bus write data.
- IOBUS_WR  out  1  write strobe.
- IOBUS_IN  in  32  combinational read data from the peripherals.
- BUSY  out  1  FIFO non-empty or FSM not IDLE.

## Operation
- Push: a command is accepted on any edge where CMD_VALID & CMD_READY. CMD_READY = !full.
- Push and pop in the same cycle are legal when the FIFO is non-full; the count is unchanged.
- FSM states are IDLE, ISSUE, WAIT and RESP.
  - IDLE: if the FIFO is non-empty, pop the head into the bus registers, go to ISSUE.
  - ISSUE: IOBUS_ADDR/IOBUS_OUT carry the command and IOBUS_WR = CMD_WR.
    - Write: go to IDLE.
    - Read with READ_WAIT = 0: capture IOBUS_IN into RSP_DATA, go to RESP.
    - Read with READ_WAIT > 0: load the wait counter with READ_WAIT, go to WAIT.
  - WAIT: IOBUS_ADDR is held and IOBUS_WR = 0. The counter decrements each cycle. On the cycle the counter is 1, capture IOBUS_IN and go to RESP.
  - RESP: RSP_VALID = 1 and RSP_DATA is stable. On RSP_READY, go to IDLE.
- IOBUS_WR is 1 only in ISSUE for a write, and for exactly one cycle per write command.
- IOBUS_ADDR and IOBUS_OUT hold their last values outside ISSUE/WAIT.
- Commands complete strictly in FIFO order. No new command issues while a response is pending (RESP stalls the queue).
- Data passes through unmodified at full 32-bit width. RSP_DATA is updated only on capture.

## Timing
- Reset values: CMD_READY = 1 (after reset release). RSP_VALID, RSP_DATA, IOBUS_ADDR, IOBUS_OUT, IOBUS_WR and BUSY are all 0. FIFO is empty, state is IDLE.
- Let k be the acceptance cycle, with the FIFO empty and the FSM in IDLE:
  - the FIFO is non-empty in cycle k+1;
  - ISSUE falls in cycle k+2, which is when IOBUS_WR pulses for a write;
  - a read samples IOBUS_IN at the end of cycle k+2+READ_WAIT;
  - RSP_VALID is high from cycle k+3+READ_WAIT.
- Queued writes issue every 2 cycles (ISSUE, IDLE, ISSUE, …).
- RSP_READY held high makes RESP last one cycle.
- RSP_VALID stays high, with RSP_DATA constant, for as long as RSP_READY is low.
- Reset assertion mid-operation clears the FIFO, the FSM, IOBUS_WR and RSP_VALID immediately, without waiting for an edge. A pending response is discarded and no partial write strobe is re-issued after release.

## Structure
- Package iobus_pkg holds:
  - iobus_cmd_t struct {wr, addr[31:0], data[31:0]};
  - the state enum;
  - the MMIO address constants SWITCHES_AD = 32'h11000000, LEDS_AD = 32'h11080000 and SSEG_AD = 32'h110C0000.
- Sub-module cmd_fifo: a parameterised synchronous FIFO of iobus_cmd_t with full/empty flags and pointers of width $clog2(FIFO_DEPTH)+1. The top level contains the FSM, the wait counter and the bus registers.

## Test plan
- Reset: hold RST_N low for 3 cycles → every output 0; after release CMD_READY = 1 and BUSY = 0.
- Single write {1, 32'h11080000, 32'h0000A5A5} accepted in cycle k → IOBUS_WR = 1 only in cycle k+2, with IOBUS_ADDR = 32'h11080000 and IOBUS_OUT = 32'h0000A5A5.
- READ_WAIT = 2, bus model returns 32'h0000BEEF when the address is 32'h11000000; read accepted in cycle k with RSP_READY low for 3 cycles → RSP_VALID rises in cycle k+5 with RSP_DATA = 32'h0000BEEF and holds until RSP_READY.
- FIFO_DEPTH = 4; a read stalled in RESP, then 5 writes offered → 4 accepted and CMD_READY = 0. After RSP_READY, the writes issue in order, 2 cycles apart, and CMD_READY returns to 1 after the first pop.
- Simultaneous push/pop: a steady stream of writes with CMD_VALID held high → no command lost or duplicated, and the IOBUS_WR count equals the accept count.
- RST_N pulled low during WAIT → RSP_VALID and BUSY are 0 immediately, no response appears after release, and the next command behaves as in the second scenario.
